sram_wb_split: RTL and testbench
================================

// Module: sram_wb_split
// PURPOSE
//  Wishbone-style slave that turns one byte or word request into one or two accesses
//  on the 16-bit asynchronous SRAM pads.
//  Sits directly downstream of the memory-map decoder and serves the RAM region.
//  Handles byte lanes, sign extension of byte reads, and odd-address word accesses.
//  An odd-address word access is split into two SRAM phases.
// PARAMETERS
//  WAIT_CYCLES  1      strobe cycles per SRAM phase (>=1); phase = 1 setup + WAIT_CYCLES
//  BASE_WORD    21'h0  word offset added to the word address driven on sram_flash_addr_
// PORTS
//  clk_i             in    1   single system clock, all logic rising-edge
//  rst_i             in    1   asynchronous, active-low reset
//  adr_i             in    20  byte address
//  dat_i             in    16  write data (byte writes use dat_i[7:0])
//  dat_o             out   16  read data, registered
//  we_i              in    1   1 = write
//  stb_i             in    1   request; held high until ack_o
//  byte_i            in    1   1 = byte access, 0 = word access
//  ack_o             out   1   one-cycle completion pulse
//  sram_flash_addr_  out   21  word address = BASE_WORD + word index
//  sram_flash_data_  inout 16  SRAM data; driven only during write phases
//  sram_flash_oe_n_  out   1   output enable, active low
//  sram_flash_we_n_  out   1   write enable, active low
//  sram_bw_          out   4   byte-lane enables, active low; [3:2] always 1
//  sram_cen_         out   1   chip enable, active low
// BEHAVIOUR
//  Reset (async, rst_i=0): state IDLE; dat_o=0; ack_o=0; addr=0; oe_n=1; we_n=1;
//   bw_=4'hf; cen_=1; data bus tri-stated. All outputs return to these values immediately.
//  States: IDLE -> P1 -> [P2] -> ACK -> IDLE. Each Pn lasts 1+WAIT_CYCLES clocks.
//  IDLE samples stb_i each edge. split = !byte_i & adr_i[0]. Request latched at that edge.
//  Word index W0 = adr_i[19:1]. In a split, W1 = W0+1 mod 2^19 (0x7FFFF wraps to 0).
//  All pad outputs are registered and stable for the whole phase.
//  cen_=0 throughout each phase. Between P1 and P2, cen_ stays low; addr/bw_ change at the P2 setup.
//  Read phase: oe_n=0, bw_[1:0]=00 for the whole phase; data sampled on the last edge of the phase.
//  Write phase: data driven for the whole phase; we_n=0 only in the strobe cycles,
//   so we_n=1 in each setup cycle, including the P2 setup.
//  Lane mapping:
//   byte rd even: dat_o = sext(d[7:0]);   byte rd odd: dat_o = sext(d[15:8]).
//   word rd even: dat_o = d.   word rd odd: dat_o = {d(W1)[7:0], d(W0)[15:8]}.
//   byte wr even: bw_=1110, lane0 = dat_i[7:0].   byte wr odd: bw_=1101, lane1 = dat_i[7:0].
//   word wr even: bw_=1100, bus = dat_i.
//   word wr odd: P1 bw_=1101, lane1 = dat_i[7:0]; P2 bw_=1110, lane0 = dat_i[15:8].
//  ACK state: ack_o=1 for exactly one cycle; dat_o updated in the same cycle.
//   Next cycle is IDLE, and a still-high stb_i there starts a new request.
//  Latency (sampling edge to ack_o high): 1+WAIT_CYCLES (single), 2*(1+WAIT_CYCLES) (split).
//  dat_o holds its value until the next read completes; writes leave dat_o unchanged.
//  stb_i dropping mid-transfer: transfer still completes and acks (protocol violation, no abort).
//  Input changes after the sampling edge are ignored until IDLE.
// TESTING
//  SRAM model [W4]=0x8c34, byte rd @0x8 -> dat_o=0x0034; byte rd @0x9 -> 0xff8c, ack at +2 (W=1).
//  Word wr 0x1234 @0x2, then word rd @0x3 with [W2]=0x0b0a -> dat_o=0x0a12, two phases, ack at +4.
//  Word wr 0xabcd @0xd -> [W6] hi=0xcd, [W7] lo=0xab, other lanes untouched.
//   Check we_n=1 in both setup cycles.
//  Back-to-back: stb_i held high, new adr on ack cycle -> second request starts next cycle, no lost ack.
//  Word rd @0xFFFFF -> phases at word 0x7FFFF then 0x00000 (+BASE_WORD).
//  Assert rst_i=0 mid-P2 of a split write -> we_n, cen_, bw_ go inactive same cycle,
//   bus tri-stated, no ack.

Source files
------------

// File: rtl/sram_wb_split.sv
// sram_wb_split: Wishbone-style byte/word slave for a 16-bit asynchronous SRAM.
// An odd-address word access becomes two SRAM phases: P1 on word W0 carries the
// low byte of the request in lane 1, P2 on word W1 carries the high byte in lane 0.
// Handshake: a request is taken when stb_i is high in IDLE at a rising edge; all
// request inputs are latched there and ignored until the one-cycle ack_o pulse,
// after which the block spends one cycle in IDLE before it can accept again.
module sram_wb_split #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [20:0] BASE_WORD   = 21'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [19:0] adr_i,
  input  logic [15:0] dat_i,
  output logic [15:0] dat_o,
  input  logic        we_i,
  input  logic        stb_i,
  input  logic        byte_i,
  output logic        ack_o,
  output logic [20:0] sram_flash_addr_,
  inout  wire  [15:0] sram_flash_data_,
  output logic        sram_flash_oe_n_,
  output logic        sram_flash_we_n_,
  output logic [3:0]  sram_bw_,
  output logic        sram_cen_
);

  typedef enum logic [1:0] {ST_IDLE, ST_P1, ST_P2, ST_ACK} state_e;

  // Phase counter: 0 is the setup cycle, 1..WAIT_CYCLES are strobe cycles.
  localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic          byte_q;
  logic          odd_q;
  logic [18:0]   widx_q;
  logic [15:0]   wdat_q;
  logic [7:0]    lo_q;     // W0[15:8] captured at the end of P1 of a split read
  logic [15:0]   dat_q;
  logic          ack_q;
  logic [20:0]   addr_q;
  logic          oe_n_q;
  logic          we_n_q;
  logic [3:0]    bw_q;
  logic          cen_q;
  logic          drv_q;
  logic [15:0]   dout_q;

  logic          is_split;
  logic [3:0]    bw_p1_d;
  logic [15:0]   dout_p1_d;
  logic [15:0]   rd_data_d;
  logic [20:0]   addr_p1_d;
  logic [20:0]   addr_p2_d;

  assign is_split  = ~byte_q & odd_q;
  assign addr_p1_d = BASE_WORD + {2'b00, adr_i[19:1]};
  assign addr_p2_d = BASE_WORD + {2'b00, widx_q + 19'd1};

  // First-phase lane enables and bus data, decoded from the incoming request.
  // Byte-wide phases put the byte on both lanes; bw_ selects which one lands.
  always_comb begin
    bw_p1_d   = 4'b1100;
    dout_p1_d = {dat_i[7:0], dat_i[7:0]};
    if (we_i) begin
      if (byte_i || adr_i[0]) begin
        bw_p1_d = adr_i[0] ? 4'b1101 : 4'b1110;
      end else begin
        dout_p1_d = dat_i;
      end
    end
  end

  // Read-data assembly from the bus at the final phase edge.
  always_comb begin
    rd_data_d = sram_flash_data_;
    if (byte_q) begin
      rd_data_d = odd_q ? {{8{sram_flash_data_[15]}}, sram_flash_data_[15:8]}
                        : {{8{sram_flash_data_[7]}},  sram_flash_data_[7:0]};
    end else if (odd_q) begin
      rd_data_d = {sram_flash_data_[7:0], lo_q};
    end
  end

  // Sequencer with registered pad controls, ack and read data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      odd_q   <= 1'b0;
      widx_q  <= '0;
      wdat_q  <= '0;
      lo_q    <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      addr_q  <= '0;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      bw_q    <= 4'hf;
      cen_q   <= 1'b1;
      drv_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (stb_i) begin
            state_q <= ST_P1;
            cnt_q   <= '0;
            we_q    <= we_i;
            byte_q  <= byte_i;
            odd_q   <= adr_i[0];
            widx_q  <= adr_i[19:1];
            wdat_q  <= dat_i;
            addr_q  <= addr_p1_d;
            cen_q   <= 1'b0;
            oe_n_q  <= we_i;
            we_n_q  <= 1'b1;
            bw_q    <= bw_p1_d;
            drv_q   <= we_i;
            dout_q  <= dout_p1_d;
          end
        end
        ST_P1, ST_P2: begin
          if (cnt_q != LAST) begin
            cnt_q  <= cnt_q + CW'(1);
            we_n_q <= ~we_q;
          end else begin
            cnt_q <= '0;
            if (state_q == ST_P1 && is_split) begin
              // cen_ stays low across the phase boundary; only addr/lanes move.
              state_q <= ST_P2;
              lo_q    <= sram_flash_data_[15:8];
              addr_q  <= addr_p2_d;
              we_n_q  <= 1'b1;
              bw_q    <= we_q ? 4'b1110 : 4'b1100;
              dout_q  <= {wdat_q[15:8], wdat_q[15:8]};
            end else begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
              if (!we_q) begin
                dat_q <= rd_data_d;
              end
              cen_q  <= 1'b1;
              oe_n_q <= 1'b1;
              we_n_q <= 1'b1;
              bw_q   <= 4'hf;
              drv_q  <= 1'b0;
            end
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dat_o            = dat_q;
  assign ack_o            = ack_q;
  assign sram_flash_addr_ = addr_q;
  assign sram_flash_oe_n_ = oe_n_q;
  assign sram_flash_we_n_ = we_n_q;
  assign sram_bw_         = bw_q;
  assign sram_cen_        = cen_q;
  assign sram_flash_data_ = drv_q ? dout_q : 16'hzzzz;

endmodule

// File: tb/tb_sram_wb_split.sv
// tb_sram_wb_split: directed scenarios against a behavioural SRAM model.
module tb_sram_wb_split;

  localparam int unsigned WAIT = 1;
  localparam logic [20:0] BASE = 21'h100;
  // Posedges counted from the request being presented (sampling edge = 1) to ack visible.
  localparam int N1 = (1 + WAIT) + 1;
  localparam int N2 = 2 * (1 + WAIT) + 1;

  // clock / reset
  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [19:0] adr_i;
  logic [15:0] dat_i;
  logic [15:0] dat_o;
  logic        we_i;
  logic        stb_i;
  logic        byte_i;
  logic        ack_o;
  logic [20:0] sram_addr;
  wire  [15:0] sram_data;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [3:0]  sram_bw;
  logic        sram_cen;

  sram_wb_split #(.WAIT_CYCLES(WAIT), .BASE_WORD(BASE)) dut (
    .clk_i(clk_i), .rst_i(rst_n), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .stb_i(stb_i), .byte_i(byte_i), .ack_o(ack_o),
    .sram_flash_addr_(sram_addr), .sram_flash_data_(sram_data),
    .sram_flash_oe_n_(sram_oe_n), .sram_flash_we_n_(sram_we_n),
    .sram_bw_(sram_bw), .sram_cen_(sram_cen)
  );

  // SRAM model: combinational read, lane-masked write while we_n is low at a clock edge.
  logic [15:0] mem [0:(1<<19)-1];
  logic [20:0] m_off;
  logic        pl_en = 1'b0;
  logic [18:0] pl_idx = '0;
  logic [15:0] pl_val = '0;
  assign m_off     = sram_addr - BASE;
  assign sram_data = (!sram_cen && !sram_oe_n && sram_we_n) ? mem[m_off[18:0]] : 16'hzzzz;

  always @(posedge clk_i) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_val;
    end else if (!sram_cen && !sram_we_n) begin
      if (!sram_bw[0]) mem[m_off[18:0]][7:0]  <= sram_data[7:0];
      if (!sram_bw[1]) mem[m_off[18:0]][15:8] <= sram_data[15:8];
    end
  end

  // scoreboard and counters
  logic [15:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // per-cycle pad trace, index 1 = cycle after the sampling edge
  logic [20:0] tr_addr [0:31];
  logic [3:0]  tr_bw   [0:31];
  logic        tr_we_n [0:31];
  logic        tr_oe_n [0:31];
  logic        tr_cen  [0:31];
  logic        tr_ack  [0:31];

  // driver tasks
  task automatic preload(input logic [18:0] idx, input logic [15:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk_i); #1;
    pl_en = 1'b0;
  endtask

  task automatic start_req(input logic we, input logic byt, input logic [19:0] adr, input logic [15:0] dat);
    we_i = we; byte_i = byt; adr_i = adr; dat_i = dat; stb_i = 1'b1;
  endtask

  task automatic wait_ack(input int max_n, input logic drop_stb, output int n, output logic got);
    n = 0; got = 1'b0;
    while (n < max_n && !got) begin
      @(posedge clk_i); #1;
      n++;
      tr_addr[n] = sram_addr; tr_bw[n] = sram_bw; tr_we_n[n] = sram_we_n;
      tr_oe_n[n] = sram_oe_n; tr_cen[n] = sram_cen; tr_ack[n] = ack_o;
      if (drop_stb && n == 1) stb_i = 1'b0;
      if (ack_o) got = 1'b1;
    end
  endtask

  task automatic end_req();
    stb_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  // scenarios
  task automatic test_reset();
    n_cmp++; if (dat_o !== 16'h0) begin n_err++; $display("FAIL reset_dat_o got=%h exp=0000", dat_o); end
    n_cmp++; if (ack_o !== 1'b0) begin n_err++; $display("FAIL reset_ack got=%b exp=0", ack_o); end
    n_cmp++; if (sram_addr !== 21'h0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", sram_addr); end
    n_cmp++; if ({sram_oe_n, sram_we_n, sram_cen} !== 3'b111) begin n_err++; $display("FAIL reset_ctl got=%b exp=111", {sram_oe_n, sram_we_n, sram_cen}); end
    n_cmp++; if (sram_bw !== 4'hf) begin n_err++; $display("FAIL reset_bw got=%b exp=1111", sram_bw); end
  endtask

  task automatic test_byte_read();
    int n; logic got; logic [15:0] e;
    preload(19'h4, 16'h8c34);
    exp_q.push_back(16'h0034);
    start_req(1'b0, 1'b1, 20'h8, 16'h0);
    wait_ack(30, 1'b0, n, got);
    e = exp_q.pop_front();
    n_cmp++; if (n !== N1) begin n_err++; $display("FAIL byte_rd_even_lat got=%0d exp=%0d", n, N1); end
    n_cmp++; if (dat_o !== e) begin n_err++; $display("FAIL byte_rd_even_data got=%h exp=%h", dat_o, e); end
    n_cmp++; if (tr_addr[1] !== BASE + 21'h4) begin n_err++; $display("FAIL byte_rd_addr got=%h exp=%h", tr_addr[1], BASE + 21'h4); end
    n_cmp++; if ({tr_bw[2], tr_oe_n[2], tr_cen[2], tr_we_n[2]} !== 7'b1100_001) begin n_err++; $display("FAIL byte_rd_pads got=%b exp=1100001", {tr_bw[2], tr_oe_n[2], tr_cen[2], tr_we_n[2]}); end
    end_req();
    n_cmp++; if (ack_o !== 1'b0) begin n_err++; $display("FAIL ack_one_cycle got=%b exp=0", ack_o); end
    exp_q.push_back(16'hff8c);
    start_req(1'b0, 1'b1, 20'h9, 16'h0);
    wait_ack(30, 1'b0, n, got);
    e = exp_q.pop_front();
    n_cmp++; if (n !== N1) begin n_err++; $display("FAIL byte_rd_odd_lat got=%0d exp=%0d", n, N1); end
    n_cmp++; if (dat_o !== e) begin n_err++; $display("FAIL byte_rd_odd_data got=%h exp=%h", dat_o, e); end
    end_req();
  endtask

  task automatic test_word_write_read();
    int n; logic got; logic [15:0] e;
    start_req(1'b1, 1'b0, 20'h2, 16'h1234);
    wait_ack(30, 1'b0, n, got);
    n_cmp++; if (n !== N1) begin n_err++; $display("FAIL word_wr_lat got=%0d exp=%0d", n, N1); end
    n_cmp++; if (tr_bw[1] !== 4'b1100) begin n_err++; $display("FAIL word_wr_bw got=%b exp=1100", tr_bw[1]); end
    n_cmp++; if (dat_o !== 16'hff8c) begin n_err++; $display("FAIL wr_keeps_dat_o got=%h exp=ff8c", dat_o); end
    end_req();
    n_cmp++; if (mem[19'h1] !== 16'h1234) begin n_err++; $display("FAIL word_wr_mem got=%h exp=1234", mem[19'h1]); end
    preload(19'h2, 16'h0b0a);
    exp_q.push_back(16'h0a12);
    start_req(1'b0, 1'b0, 20'h3, 16'h0);
    wait_ack(30, 1'b0, n, got);
    e = exp_q.pop_front();
    n_cmp++; if (n !== N2) begin n_err++; $display("FAIL split_rd_lat got=%0d exp=%0d", n, N2); end
    n_cmp++; if (dat_o !== e) begin n_err++; $display("FAIL split_rd_data got=%h exp=%h", dat_o, e); end
    n_cmp++; if ({tr_addr[1], tr_addr[3]} !== {BASE + 21'h1, BASE + 21'h2}) begin n_err++; $display("FAIL split_rd_addr got=%h/%h exp=%h/%h", tr_addr[1], tr_addr[3], BASE + 21'h1, BASE + 21'h2); end
    n_cmp++; if ({tr_cen[2], tr_cen[3]} !== 2'b00) begin n_err++; $display("FAIL split_rd_cen got=%b exp=00", {tr_cen[2], tr_cen[3]}); end
    end_req();
  endtask

  task automatic test_byte_write();
    int n; logic got; logic [15:0] e;
    preload(19'h8, 16'h7777);
    start_req(1'b1, 1'b1, 20'h10, 16'hee5a);
    wait_ack(30, 1'b0, n, got);
    n_cmp++; if (tr_bw[1] !== 4'b1110) begin n_err++; $display("FAIL byte_wr_even_bw got=%b exp=1110", tr_bw[1]); end
    end_req();
    start_req(1'b1, 1'b1, 20'h11, 16'h33a5);
    wait_ack(30, 1'b0, n, got);
    n_cmp++; if (tr_bw[1] !== 4'b1101) begin n_err++; $display("FAIL byte_wr_odd_bw got=%b exp=1101", tr_bw[1]); end
    n_cmp++; if (dat_o !== 16'h0a12) begin n_err++; $display("FAIL byte_wr_keeps_dat_o got=%h exp=0a12", dat_o); end
    end_req();
    n_cmp++; if (mem[19'h8] !== 16'ha55a) begin n_err++; $display("FAIL byte_wr_mem got=%h exp=a55a", mem[19'h8]); end
    exp_q.push_back(16'hffa5);
    start_req(1'b0, 1'b1, 20'h11, 16'h0);
    wait_ack(30, 1'b0, n, got);
    e = exp_q.pop_front();
    n_cmp++; if (dat_o !== e) begin n_err++; $display("FAIL byte_rd_sext got=%h exp=%h", dat_o, e); end
    end_req();
  endtask

  task automatic test_split_write();
    int n; logic got;
    preload(19'h6, 16'h1111);
    preload(19'h7, 16'h2222);
    start_req(1'b1, 1'b0, 20'hd, 16'habcd);
    wait_ack(30, 1'b0, n, got);
    n_cmp++; if (n !== N2) begin n_err++; $display("FAIL split_wr_lat got=%0d exp=%0d", n, N2); end
    n_cmp++; if ({tr_we_n[1], tr_we_n[2], tr_we_n[3], tr_we_n[4]} !== 4'b1010) begin n_err++; $display("FAIL split_wr_we_n got=%b exp=1010", {tr_we_n[1], tr_we_n[2], tr_we_n[3], tr_we_n[4]}); end
    n_cmp++; if ({tr_bw[1], tr_bw[3]} !== 8'b1101_1110) begin n_err++; $display("FAIL split_wr_bw got=%b exp=11011110", {tr_bw[1], tr_bw[3]}); end
    n_cmp++; if ({tr_addr[2], tr_addr[3]} !== {BASE + 21'h6, BASE + 21'h7}) begin n_err++; $display("FAIL split_wr_addr got=%h/%h exp=%h/%h", tr_addr[2], tr_addr[3], BASE + 21'h6, BASE + 21'h7); end
    n_cmp++; if ({tr_cen[1], tr_cen[2], tr_cen[3], tr_cen[4]} !== 4'b0000) begin n_err++; $display("FAIL split_wr_cen got=%b exp=0000", {tr_cen[1], tr_cen[2], tr_cen[3], tr_cen[4]}); end
    end_req();
    n_cmp++; if (mem[19'h6] !== 16'hcd11) begin n_err++; $display("FAIL split_wr_w6 got=%h exp=cd11", mem[19'h6]); end
    n_cmp++; if (mem[19'h7] !== 16'h22ab) begin n_err++; $display("FAIL split_wr_w7 got=%h exp=22ab", mem[19'h7]); end
  endtask

  task automatic test_back_to_back();
    int n; logic got; logic [15:0] e;
    exp_q.push_back(16'ha55a);
    start_req(1'b0, 1'b0, 20'h10, 16'h0);
    wait_ack(30, 1'b0, n, got);
    e = exp_q.pop_front();
    n_cmp++; if (dat_o !== e) begin n_err++; $display("FAIL b2b_first_data got=%h exp=%h", dat_o, e); end
    // stb_i stays high; the next request is presented during the ack cycle
    exp_q.push_back(16'h0034);
    adr_i = 20'h8; byte_i = 1'b1;
    wait_ack(30, 1'b0, n, got);
    e = exp_q.pop_front();
    n_cmp++; if (n !== N1 + 1) begin n_err++; $display("FAIL b2b_second_lat got=%0d exp=%0d", n, N1 + 1); end
    n_cmp++; if (tr_ack[1] !== 1'b0) begin n_err++; $display("FAIL b2b_ack_gap got=%b exp=0", tr_ack[1]); end
    n_cmp++; if (dat_o !== e) begin n_err++; $display("FAIL b2b_second_data got=%h exp=%h", dat_o, e); end
    end_req();
  endtask

  task automatic test_wrap();
    int n; logic got; logic [15:0] e;
    preload(19'h7ffff, 16'hbeef);
    preload(19'h0, 16'hc0de);
    exp_q.push_back(16'hdebe);
    start_req(1'b0, 1'b0, 20'hfffff, 16'h0);
    wait_ack(30, 1'b0, n, got);
    e = exp_q.pop_front();
    n_cmp++; if (n !== N2) begin n_err++; $display("FAIL wrap_lat got=%0d exp=%0d", n, N2); end
    n_cmp++; if (dat_o !== e) begin n_err++; $display("FAIL wrap_data got=%h exp=%h", dat_o, e); end
    n_cmp++; if ({tr_addr[1], tr_addr[3]} !== {BASE + 21'h7ffff, BASE}) begin n_err++; $display("FAIL wrap_addr got=%h/%h exp=%h/%h", tr_addr[1], tr_addr[3], BASE + 21'h7ffff, BASE); end
    end_req();
  endtask

  task automatic test_reset_mid_split();
    int n; logic got; logic [15:0] e; logic ack_seen;
    preload(19'h14, 16'h0000);
    preload(19'h15, 16'h3333);
    start_req(1'b1, 1'b0, 20'h29, 16'h5566);
    repeat (4) begin @(posedge clk_i); #1; end
    n_cmp++; if ({sram_we_n, sram_cen, sram_bw} !== 6'b00_1110) begin n_err++; $display("FAIL mid_p2_pads got=%b exp=001110", {sram_we_n, sram_cen, sram_bw}); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({sram_we_n, sram_cen, sram_oe_n, sram_bw} !== 7'b111_1111) begin n_err++; $display("FAIL async_rst_pads got=%b exp=1111111", {sram_we_n, sram_cen, sram_oe_n, sram_bw}); end
    n_cmp++; if ({ack_o, dat_o} !== 17'h0) begin n_err++; $display("FAIL async_rst_ack_dat got=%b/%h exp=0/0000", ack_o, dat_o); end
    stb_i = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      if (ack_o) ack_seen = 1'b1;
    end
    rst_n = 1'b1;
    @(posedge clk_i); #1;
    if (ack_o) ack_seen = 1'b1;
    n_cmp++; if (ack_seen !== 1'b0) begin n_err++; $display("FAIL rst_no_ack got=%b exp=0", ack_seen); end
    n_cmp++; if (mem[19'h15] !== 16'h3333) begin n_err++; $display("FAIL rst_w15_untouched got=%h exp=3333", mem[19'h15]); end
    n_cmp++; if (mem[19'h14] !== 16'h6600) begin n_err++; $display("FAIL rst_w14_p1 got=%h exp=6600", mem[19'h14]); end
    // recovery read with stb_i dropped right after the sampling edge
    exp_q.push_back(16'h6600);
    start_req(1'b0, 1'b0, 20'h28, 16'h0);
    wait_ack(30, 1'b1, n, got);
    e = exp_q.pop_front();
    n_cmp++; if (n !== N1) begin n_err++; $display("FAIL stb_drop_lat got=%0d exp=%0d", n, N1); end
    n_cmp++; if (dat_o !== e) begin n_err++; $display("FAIL stb_drop_data got=%h exp=%h", dat_o, e); end
    end_req();
  endtask

  initial begin
    adr_i = '0; dat_i = '0; we_i = 1'b0; stb_i = 1'b0; byte_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk_i); #1;
    test_byte_read();
    test_word_write_read();
    test_byte_write();
    test_split_write();
    test_back_to_back();
    test_wrap();
    test_reset_mid_split();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
